// File: rtl/iob_mem_arbiter.sv
// Two-port IOb arbiter: an instruction port (read only) and a data port
// share one memory port. One outstanding transaction at a time, with either
// round-robin or fixed data-port priority.
module iob_mem_arbiter #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32,
   parameter int DPRIO  = 0
) (
   input  logic                clk_i,
   input  logic                cke_i,
   input  logic                arst_i,
   // instruction port
   input  logic                i_avalid_i,
   input  logic [ADDR_W-1:0]   i_addr_i,
   output logic                i_ready_o,
   output logic [DATA_W-1:0]   i_rdata_o,
   output logic                i_rvalid_o,
   // data port
   input  logic                d_avalid_i,
   input  logic [ADDR_W-1:0]   d_addr_i,
   input  logic [DATA_W-1:0]   d_wdata_i,
   input  logic [DATA_W/8-1:0] d_wstrb_i,
   output logic                d_ready_o,
   output logic [DATA_W-1:0]   d_rdata_o,
   output logic                d_rvalid_o,
   // shared memory port
   output logic                m_avalid_o,
   output logic [ADDR_W-1:0]   m_addr_o,
   output logic [DATA_W-1:0]   m_wdata_o,
   output logic [DATA_W/8-1:0] m_wstrb_o,
   input  logic                m_ready_i,
   input  logic [DATA_W-1:0]   m_rdata_i,
   input  logic                m_rvalid_i,
   // current owner {D,I}
   output logic [1:0]          grant_o
);

   typedef enum logic [1:0] {StIdle, StGrant, StWaitR} state_t;

   state_t     state_q, state_d;
   logic [1:0] owner_q, owner_d;    // one-hot {D,I}, cleared whenever idle
   logic       last_d_q, last_d_d;  // 1 when the data port completed last

   logic sel_d;
   logic own_avalid;
   logic own_write;
   logic win_d;
   logic in_grant;
   logic in_wait;

   assign sel_d      = owner_q[1];
   assign own_avalid = sel_d ? d_avalid_i : i_avalid_i;
   assign own_write  = sel_d && (d_wstrb_i != '0);
   assign in_grant   = (state_q == StGrant);
   assign in_wait    = (state_q == StWaitR);

   // Winner selection in idle; a tie goes to the port that did not complete last
   always_comb begin
      win_d = 1'b0;
      if (i_avalid_i && d_avalid_i) begin
         win_d = (DPRIO != 0) ? 1'b1 : ~last_d_q;
      end else begin
         win_d = d_avalid_i;
      end
   end

   // Next-state, owner and round-robin pointer
   always_comb begin
      state_d  = state_q;
      owner_d  = owner_q;
      last_d_d = last_d_q;
      unique case (state_q)
         StIdle: begin
            if (i_avalid_i || d_avalid_i) begin
               owner_d = win_d ? 2'b10 : 2'b01;
               state_d = StGrant;
            end
         end
         StGrant: begin
            if (!own_avalid) begin
               // abandoned request: no completion, pointer untouched
               state_d = StIdle;
               owner_d = 2'b00;
            end else if (m_ready_i) begin
               if (own_write) begin
                  state_d  = StIdle;
                  owner_d  = 2'b00;
                  last_d_d = 1'b1;
               end else begin
                  state_d = StWaitR;
               end
            end
         end
         StWaitR: begin
            if (m_rvalid_i) begin
               state_d  = StIdle;
               owner_d  = 2'b00;
               last_d_d = sel_d;
            end
         end
         default: begin
            state_d = StIdle;
            owner_d = 2'b00;
         end
      endcase
   end

   // State register; clock enable freezes everything
   always_ff @(posedge clk_i or posedge arst_i) begin
      if (arst_i) begin
         state_q  <= StIdle;
         owner_q  <= 2'b00;
         last_d_q <= 1'b1;
      end else if (cke_i) begin
         state_q  <= state_d;
         owner_q  <= owner_d;
         last_d_q <= last_d_d;
      end
   end

   // Request forwarding, handshakes and read-data routing from held state
   always_comb begin
      m_avalid_o = 1'b0;
      m_addr_o   = '0;
      m_wdata_o  = '0;
      m_wstrb_o  = '0;
      i_ready_o  = 1'b0;
      d_ready_o  = 1'b0;
      i_rvalid_o = 1'b0;
      d_rvalid_o = 1'b0;
      i_rdata_o  = '0;
      d_rdata_o  = '0;
      if (in_grant) begin
         m_avalid_o = own_avalid;
         m_addr_o   = sel_d ? d_addr_i : i_addr_i;
         if (sel_d) begin
            m_wdata_o = d_wdata_i;
            m_wstrb_o = d_wstrb_i;
         end
         i_ready_o = owner_q[0] & m_ready_i;
         d_ready_o = owner_q[1] & m_ready_i;
      end
      if (in_wait && m_rvalid_i) begin
         if (owner_q[0]) begin
            i_rvalid_o = 1'b1;
            i_rdata_o  = m_rdata_i;
         end
         if (owner_q[1]) begin
            d_rvalid_o = 1'b1;
            d_rdata_o  = m_rdata_i;
         end
      end
   end

   assign grant_o = owner_q;

endmodule

// File: tb/tb_iob_mem_arbiter.sv
// Directed bench for iob_mem_arbiter: one round-robin instance driven step by
// step, one fixed-priority instance, with queue-based expected results.
module tb_iob_mem_arbiter;

   localparam int          AW    = 32;
   localparam int          DW    = 32;
   localparam logic [31:0] MAGIC = 32'hA5A5_0000;
   localparam logic [31:0] IA    = 32'h0000_1000;
   localparam logic [31:0] DA    = 32'h0000_2000;

   typedef struct packed {
      logic [1:0]  g;
      logic [31:0] a;
   } acc_t;

   logic clk = 1'b0;
   logic arst, cke;

   // round-robin instance
   logic          i_avalid, i_ready, i_rvalid, d_avalid, d_ready, d_rvalid;
   logic [AW-1:0] i_addr, d_addr, m_addr;
   logic [DW-1:0] i_rdata, d_rdata, d_wdata, m_wdata, m_rdata;
   logic [3:0]    d_wstrb, m_wstrb;
   logic          m_avalid, m_ready, m_rvalid;
   logic [1:0]    grant;
   logic          auto, man_ready, man_rvalid;
   logic [DW-1:0] man_rdata;
   logic          a_rvalid = 1'b0;
   logic [DW-1:0] a_rdata  = '0;

   // fixed-priority instance
   logic          i1_avalid, i1_ready, i1_rvalid, d1_avalid, d1_ready, d1_rvalid;
   logic [AW-1:0] i1_addr, d1_addr, m1_addr;
   logic [DW-1:0] i1_rdata, d1_rdata, m1_wdata;
   logic [3:0]    m1_wstrb;
   logic          m1_avalid, m1_rvalid = 1'b0;
   logic [DW-1:0] m1_rdata = '0;
   logic [1:0]    grant1;

   int n_chk = 0, n_fail = 0;
   int acc0_cnt = 0, acc1_cnt = 0, i1_grant_cnt = 0;
   acc_t        exp_acc0[$], exp_acc1[$];
   logic [31:0] exp_i0[$], exp_d0[$];

   assign m_ready  = auto ? 1'b1 : man_ready;
   assign m_rvalid = auto ? a_rvalid : man_rvalid;
   assign m_rdata  = auto ? a_rdata : man_rdata;

   iob_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .DPRIO(0)) dut0 (
      .clk_i(clk), .cke_i(cke), .arst_i(arst),
      .i_avalid_i(i_avalid), .i_addr_i(i_addr), .i_ready_o(i_ready),
      .i_rdata_o(i_rdata), .i_rvalid_o(i_rvalid),
      .d_avalid_i(d_avalid), .d_addr_i(d_addr), .d_wdata_i(d_wdata), .d_wstrb_i(d_wstrb),
      .d_ready_o(d_ready), .d_rdata_o(d_rdata), .d_rvalid_o(d_rvalid),
      .m_avalid_o(m_avalid), .m_addr_o(m_addr), .m_wdata_o(m_wdata), .m_wstrb_o(m_wstrb),
      .m_ready_i(m_ready), .m_rdata_i(m_rdata), .m_rvalid_i(m_rvalid),
      .grant_o(grant)
   );

   iob_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .DPRIO(1)) dut1 (
      .clk_i(clk), .cke_i(cke), .arst_i(arst),
      .i_avalid_i(i1_avalid), .i_addr_i(i1_addr), .i_ready_o(i1_ready),
      .i_rdata_o(i1_rdata), .i_rvalid_o(i1_rvalid),
      .d_avalid_i(d1_avalid), .d_addr_i(d1_addr), .d_wdata_i('0), .d_wstrb_i(4'h0),
      .d_ready_o(d1_ready), .d_rdata_o(d1_rdata), .d_rvalid_o(d1_rvalid),
      .m_avalid_o(m1_avalid), .m_addr_o(m1_addr), .m_wdata_o(m1_wdata), .m_wstrb_o(m1_wstrb),
      .m_ready_i(1'b1), .m_rdata_i(m1_rdata), .m_rvalid_i(m1_rvalid),
      .grant_o(grant1)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic smp();
      @(negedge clk);
   endtask

   // memory models: read data one cycle after acceptance
   always @(posedge clk) begin
      a_rvalid <= m_avalid && m_ready && (m_wstrb == 4'h0);
      a_rdata  <= m_addr ^ MAGIC;
      m1_rvalid <= m1_avalid && (m1_wstrb == 4'h0);
      m1_rdata  <= m1_addr ^ MAGIC;
   end

   // scoreboard for the round-robin instance
   always @(negedge clk) begin
      acc_t  e;
      logic [31:0] x;
      if (m_avalid && m_ready) begin
         acc0_cnt++;
         chk("acc0_pending", 64'(exp_acc0.size() > 0), 64'd1);
         if (exp_acc0.size() > 0) begin
            e = exp_acc0.pop_front();
            chk("acc0_grant", 64'(grant), 64'(e.g));
            chk("acc0_addr", 64'(m_addr), 64'(e.a));
         end
      end
      if (i_rvalid) begin
         chk("i_rvalid_pending", 64'(exp_i0.size() > 0), 64'd1);
         if (exp_i0.size() > 0) begin
            x = exp_i0.pop_front();
            chk("i_rdata", 64'(i_rdata), 64'(x));
         end
      end
      if (d_rvalid) begin
         chk("d_rvalid_pending", 64'(exp_d0.size() > 0), 64'd1);
         if (exp_d0.size() > 0) begin
            x = exp_d0.pop_front();
            chk("d_rdata", 64'(d_rdata), 64'(x));
         end
      end
   end

   // scoreboard for the fixed-priority instance
   always @(negedge clk) begin
      acc_t e;
      if (grant1[0]) i1_grant_cnt++;
      if (m1_avalid) begin
         acc1_cnt++;
         chk("acc1_pending", 64'(exp_acc1.size() > 0), 64'd1);
         if (exp_acc1.size() > 0) begin
            e = exp_acc1.pop_front();
            chk("acc1_grant", 64'(grant1), 64'(e.g));
            chk("acc1_addr", 64'(m1_addr), 64'(e.a));
         end
      end
      if (d1_rvalid) chk("d1_rdata", 64'(d1_rdata), 64'(d1_addr ^ MAGIC));
   end

   initial begin
      #200000;
      $display("FAIL global_timeout observed=running required=finished");
      $fatal(1);
   end

   initial begin
      int base;
      arst = 1'b1; cke = 1'b1; auto = 1'b0;
      i_avalid = 0; i_addr = '0; d_avalid = 0; d_addr = '0; d_wdata = '0; d_wstrb = '0;
      man_ready = 0; man_rvalid = 0; man_rdata = '0;
      i1_avalid = 0; i1_addr = '0; d1_avalid = 0; d1_addr = '0;

      // reset state
      smp();
      chk("rst_grant", 64'(grant), 64'd0);
      chk("rst_m_avalid", 64'(m_avalid), 64'd0);
      chk("rst_m_addr", 64'(m_addr), 64'd0);
      chk("rst_ready", 64'({i_ready, d_ready}), 64'd0);
      chk("rst_rvalid", 64'({i_rvalid, d_rvalid}), 64'd0);
      chk("rst_grant1", 64'(grant1), 64'd0);
      cyc(); arst = 1'b0;

      // instruction read, data returned on the second wait cycle
      cyc(); i_avalid = 1; i_addr = 32'h100; man_ready = 1;
      exp_acc0.push_back('{2'b01, 32'h100}); exp_i0.push_back(32'hDEADBEEF);
      smp(); chk("ird_idle_avalid", 64'(m_avalid), 64'd0); chk("ird_idle_grant", 64'(grant), 64'd0);
      cyc(); smp();
      chk("ird_m_avalid", 64'(m_avalid), 64'd1);
      chk("ird_m_addr", 64'(m_addr), 64'h100);
      chk("ird_grant", 64'(grant), 64'b01);
      chk("ird_i_ready", 64'(i_ready), 64'd1);
      chk("ird_d_ready", 64'(d_ready), 64'd0);
      chk("ird_wstrb_wdata", 64'({m_wstrb, m_wdata}), 64'd0);
      cyc(); i_avalid = 0;
      smp(); chk("ird_wait_grant", 64'(grant), 64'b01); chk("ird_wait_avalid", 64'(m_avalid), 64'd0);
      chk("ird_wait_addr", 64'(m_addr), 64'd0);
      cyc(); man_rvalid = 1; man_rdata = 32'hDEADBEEF;
      smp(); chk("ird_i_rvalid", 64'(i_rvalid), 64'd1); chk("ird_i_rdata", 64'(i_rdata), 64'hDEADBEEF);
      chk("ird_d_rvalid", 64'(d_rvalid), 64'd0); chk("ird_rv_grant", 64'(grant), 64'b01);
      cyc(); man_rvalid = 0;
      smp(); chk("ird_done_grant", 64'(grant), 64'd0);

      // data write completes on the handshake
      cyc(); d_avalid = 1; d_addr = 32'h200; d_wdata = 32'h12345678; d_wstrb = 4'hF;
      exp_acc0.push_back('{2'b10, 32'h200});
      smp(); chk("dwr_idle_grant", 64'(grant), 64'd0);
      cyc(); smp();
      chk("dwr_d_ready", 64'(d_ready), 64'd1);
      chk("dwr_m_wstrb", 64'(m_wstrb), 64'hF);
      chk("dwr_m_wdata", 64'(m_wdata), 64'h12345678);
      chk("dwr_grant", 64'(grant), 64'b10);
      chk("dwr_i_ready", 64'(i_ready), 64'd0);
      cyc(); d_avalid = 0; d_wstrb = 4'h0;
      smp(); chk("dwr_back_idle", 64'(grant), 64'd0); chk("dwr_no_avalid", 64'(m_avalid), 64'd0);
      cyc(); smp(); chk("dwr_no_rvalid", 64'(d_rvalid), 64'd0);

      // tie after a data completion goes to I; memory stalls 5 cycles
      cyc(); man_ready = 0; i_avalid = 1; i_addr = 32'h300; d_avalid = 1; d_addr = 32'h400;
      exp_acc0.push_back('{2'b01, 32'h300});
      smp(); chk("stl_idle_grant", 64'(grant), 64'd0);
      for (int k = 0; k < 5; k++) begin
         cyc(); smp();
         chk("stl_avalid", 64'(m_avalid), 64'd1);
         chk("stl_addr", 64'(m_addr), 64'h300);
         chk("stl_ready", 64'({i_ready, d_ready}), 64'd0);
         chk("stl_grant", 64'(grant), 64'b01);
      end
      cyc(); man_ready = 1;
      smp(); chk("stl_i_ready", 64'(i_ready), 64'd1); chk("stl_d_ready", 64'(d_ready), 64'd0);
      cyc(); i_avalid = 0;
      smp(); chk("stl_wait_grant", 64'(grant), 64'b01); chk("stl_wait_d_ready", 64'(d_ready), 64'd0);

      // reset in the read wait, then a stale response
      cyc(); arst = 1; d_avalid = 0;
      smp(); chk("ars_grant", 64'(grant), 64'd0); chk("ars_avalid", 64'(m_avalid), 64'd0);
      cyc(); arst = 0; man_rvalid = 1; man_rdata = 32'hBAD0BAD0;
      smp(); chk("ars_rvalid", 64'({i_rvalid, d_rvalid}), 64'd0); chk("ars_grant2", 64'(grant), 64'd0);
      cyc(); man_rvalid = 0;

      // clock enable low freezes idle and read-wait
      cke = 0; i_avalid = 1; i_addr = 32'h500; man_ready = 0;
      exp_acc0.push_back('{2'b01, 32'h500});
      smp(); chk("cke_idle_grant", 64'(grant), 64'd0);
      cyc(); smp(); chk("cke_held_idle", 64'(grant), 64'd0); chk("cke_held_avalid", 64'(m_avalid), 64'd0);
      cyc(); cke = 1;
      cyc(); smp(); chk("cke_grant", 64'(grant), 64'b01); chk("cke_avalid", 64'(m_avalid), 64'd1);
      cyc(); man_ready = 1;
      smp(); chk("cke_i_ready", 64'(i_ready), 64'd1);
      cyc(); i_avalid = 0; man_ready = 0; cke = 0; man_rvalid = 1; man_rdata = 32'h11111111;
      exp_i0.push_back(32'h11111111); exp_i0.push_back(32'h22222222);
      smp(); chk("cke_rv1", 64'(i_rvalid), 64'd1);
      cyc(); man_rvalid = 0;
      smp(); chk("cke_wait_held", 64'(grant), 64'b01);
      cyc(); cke = 1; man_rvalid = 1; man_rdata = 32'h22222222;
      smp(); chk("cke_rv2", 64'(i_rvalid), 64'd1);
      cyc(); man_rvalid = 0;
      smp(); chk("cke_done", 64'(grant), 64'd0);

      // round-robin from reset: I, D, I, D
      cyc(); arst = 1;
      cyc(); arst = 0;
      exp_acc0.push_back('{2'b01, IA}); exp_acc0.push_back('{2'b10, DA});
      exp_acc0.push_back('{2'b01, IA}); exp_acc0.push_back('{2'b10, DA});
      exp_i0.push_back(IA ^ MAGIC); exp_i0.push_back(IA ^ MAGIC);
      exp_d0.push_back(DA ^ MAGIC); exp_d0.push_back(DA ^ MAGIC);
      base = acc0_cnt;
      auto = 1; i_avalid = 1; i_addr = IA; d_avalid = 1; d_addr = DA; d_wstrb = 4'h0;
      for (int k = 0; k < 200 && acc0_cnt < base + 4; k++) begin
         @(negedge clk); #1;
      end
      chk("rr_accepts", 64'(acc0_cnt - base), 64'd4);
      cyc(); i_avalid = 0; d_avalid = 0;
      repeat (4) cyc();
      chk("rr_acc_left", 64'(exp_acc0.size()), 64'd0);
      chk("rr_i_left", 64'(exp_i0.size()), 64'd0);
      chk("rr_d_left", 64'(exp_d0.size()), 64'd0);
      auto = 0;

      // fixed data priority under continuous contention
      repeat (3) exp_acc1.push_back('{2'b10, DA});
      base = acc1_cnt;
      i1_avalid = 1; i1_addr = IA; d1_avalid = 1; d1_addr = DA;
      for (int k = 0; k < 200 && acc1_cnt < base + 3; k++) begin
         @(negedge clk); #1;
      end
      chk("dp_accepts", 64'(acc1_cnt - base), 64'd3);
      chk("dp_i_grants", 64'(i1_grant_cnt), 64'd0);
      cyc(); d1_avalid = 0; i1_avalid = 0;
      repeat (4) cyc();
      chk("dp_acc_left", 64'(exp_acc1.size()), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/iob_mem_arbiter.md
IOB_MEM_ARBITER -- requirements
Module: iob_mem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 32, address width of all three IOb ports.
REQ-002 Parameter DATA_W, default 32, data width; strobe width is DATA_W/8.
REQ-003 Parameter DPRIO, default 0; 0 = round-robin, 1 = data port has fixed priority.
REQ-004 clk_i  in  1  system clock; the block uses this single clock.
REQ-005 cke_i  in  1  clock enable; when 0, all state SHALL hold.
REQ-006 arst_i  in  1  asynchronous, active-high reset.
REQ-007 i_avalid_i  in  1  instruction read request.
REQ-008 i_addr_i  in  ADDR_W  instruction address.
REQ-009 i_ready_o  out  1  instruction request accepted.
REQ-010 i_rdata_o  out  DATA_W  instruction read data.
REQ-011 i_rvalid_o  out  1  instruction read data valid.
REQ-012 d_avalid_i, d_addr_i, d_wdata_i, d_wstrb_i  in  1/ADDR_W/DATA_W/DATA_W/8  data request; wstrb!=0 means write.
REQ-013 d_ready_o, d_rdata_o, d_rvalid_o  out  1/DATA_W/1  data port response.
REQ-014 m_avalid_o, m_addr_o, m_wdata_o, m_wstrb_o  out  1/ADDR_W/DATA_W/DATA_W/8  shared memory request.
REQ-015 m_ready_i, m_rdata_i, m_rvalid_i  in  1/DATA_W/1  shared memory response.
REQ-016 grant_o  out  2  one-hot current owner {D,I}; 00 when idle.

Function
REQ-017 FSM states SHALL be IDLE, GRANT, WAIT_R.
REQ-018 IDLE: if any avalid, select winner, register owner, go to GRANT next cycle; else stay.
REQ-019 Tie (both avalid in IDLE): DPRIO=1 -> D wins; DPRIO=0 -> port not granted last wins.
REQ-020 Round-robin last-grant pointer SHALL update only on transaction completion.
REQ-021 GRANT: m_* request fields SHALL equal owner's fields combinationally; m_avalid_o = owner avalid.
REQ-022 GRANT: owner ready_o = m_ready_i; non-owner ready_o SHALL be 0.
REQ-023 GRANT, m_avalid_o&&m_ready_i, write -> IDLE (transaction complete).
REQ-024 GRANT, m_avalid_o&&m_ready_i, read -> WAIT_R.
REQ-025 GRANT, owner drops avalid before ready -> IDLE, no completion, pointer unchanged.
REQ-026 WAIT_R: m_rvalid_i, m_rdata_i SHALL route to owner rvalid/rdata same cycle; on m_rvalid_i -> IDLE (complete).
REQ-027 m_rvalid_i in GRANT or IDLE SHALL be ignored; non-owner rvalid_o always 0.
REQ-028 At most one outstanding transaction; minimum latency request-to-m_avalid_o is 1 cycle.
REQ-029 Instruction port SHALL drive m_wstrb_o = 0 and m_wdata_o = 0 when owner.
REQ-030 Outside GRANT, m_avalid_o, m_addr_o, m_wdata_o, m_wstrb_o SHALL be 0.
REQ-031 grant_o SHALL be non-zero in GRANT and WAIT_R only.

Reset
REQ-032 On arst_i: state=IDLE, owner cleared, last-grant pointer=D (so I wins first tie), all outputs 0.
REQ-033 Reset mid-transaction SHALL abandon it; a late m_rvalid_i after reset SHALL be dropped.
REQ-034 cke_i=0 SHALL freeze state, owner and pointer; combinational forwarding follows held state.

Verification
REQ-035 I read 0x100 alone, m_ready_i=1, m_rvalid_i 2 cycles later with 0xDEADBEEF -> m_addr_o=0x100 one cycle after request, i_rvalid_o=1 with i_rdata_o=0xDEADBEEF, grant_o=01 through WAIT_R.
REQ-036 D write 0x200 data 0x12345678 wstrb 0xF, m_ready_i=1 -> d_ready_o=1 that cycle, FSM returns to IDLE next cycle, no d_rvalid_o.
REQ-037 DPRIO=0, both ports request reads continuously after reset -> grants alternate I, D, I, D.
REQ-038 DPRIO=1, both request continuously -> D granted every transaction, I never granted while D asserted.
REQ-039 Read granted, m_ready_i held 0 for 5 cycles -> m_avalid_o stays 1, m_addr_o stable, non-owner ready_o=0 throughout.
REQ-040 arst_i pulsed in WAIT_R, then m_rvalid_i=1 -> no rvalid_o to either port, grant_o=00.
